// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_IF = 1'b0,
    ARB_LS = 1'b1
  } arb_id_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned CNT_W      = 3;

  // Out-of-range latencies are clamped so the counter can never wrap.
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
    if (lat < RD_LAT_MIN) begin
      return CNT_W'(RD_LAT_MIN);
    end else if (lat > RD_LAT_MAX) begin
      return CNT_W'(RD_LAT_MAX);
    end else begin
      return CNT_W'(lat);
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between fetch and load/store; a tie goes to the
// requester that was not served last.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic    req_if_i,
  input  logic    req_ls_i,
  input  logic    last_if_i,
  output logic    gnt_valid_o,
  output arb_id_e gnt_id_o
);

  // Grant decode
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = ARB_LS;
    case ({req_if_i, req_ls_i})
      2'b10: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = ARB_IF;
      end
      2'b01: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = ARB_LS;
      end
      2'b11: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = last_if_i ? ARB_LS : ARB_IF;
      end
      default: begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = ARB_LS;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: issues one fetch or load/store access at a time,
// waits out the read latency and returns a one-cycle ack to the winner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [31:0]   if_rdata_o,
  input  logic          ls_rena_i,
  input  logic          ls_wena_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [31:0]   ls_wdata_i,
  input  logic [3:0]    ls_wstrb_i,
  output logic          ls_ack_o,
  output logic [31:0]   ls_rdata_o,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          busy_o
);

  localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(RD_LAT);

  arb_state_e       state_q, state_d;
  arb_id_e          winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_if_q, last_if_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      ls_rdata_q, ls_rdata_d;

  logic             gnt_valid_s;
  arb_id_e          gnt_id_s;

  rr_arb2 u_rr_arb2 (
    .req_if_i    (if_req_i),
    .req_ls_i    (ls_rena_i | ls_wena_i),
    .last_if_i   (last_if_q),
    .gnt_valid_o (gnt_valid_s),
    .gnt_id_o    (gnt_id_s)
  );

  // Next-state, issue and capture logic
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    cnt_d       = cnt_q;
    last_if_d   = last_if_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    mem_en_o    = 1'b0;
    mem_we_o    = 4'b0000;
    mem_addr_o  = if_addr_i;
    mem_wdata_o = ls_wdata_i;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid_s) begin
          mem_en_o = rst_n;
          winner_d = gnt_id_s;
          if (gnt_id_s == ARB_LS) begin
            mem_addr_o = ls_addr_i;
            if (ls_wena_i) begin
              mem_we_o = ls_wstrb_i & {4{rst_n}};
              state_d  = ARB_DONE;
            end else begin
              cnt_d   = LAT_LOAD;
              state_d = ARB_RD;
            end
          end else begin
            cnt_d   = LAT_LOAD;
            state_d = ARB_RD;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_RD: begin
        // Read data is valid in the cycle the counter shows one.
        if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          if (winner_q == ARB_IF) begin
            if_rdata_d = mem_rdata_i;
          end else begin
            ls_rdata_d = mem_rdata_i;
          end
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ARB_DONE: begin
        last_if_d = (winner_q == ARB_IF);
        state_d   = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      winner_q   <= ARB_IF;
      cnt_q      <= {CNT_W{1'b0}};
      last_if_q  <= 1'b1;
      if_rdata_q <= 32'h0000_0000;
      ls_rdata_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      cnt_q      <= cnt_d;
      last_if_q  <= last_if_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_ack_o   = (state_q == ARB_DONE) && (winner_q == ARB_IF);
  assign ls_ack_o   = (state_q == ARB_DONE) && (winner_q == ARB_LS);
  assign if_rdata_o = if_rdata_q;
  assign ls_rdata_o = ls_rdata_q;
  assign busy_o     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one RD_LAT=1 instance with a byte-
// writable memory model, one RD_LAT=4 instance used for the reset-abort case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst4_n;
  logic        if_req, ls_rena, ls_wena, if_req4;
  logic        ls_off;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_wstrb;

  logic        if_ack1, ls_ack1, mem_en1, busy1;
  logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1;
  logic [31:0] mem_rdata1 = 32'h0;
  logic [3:0]  mem_we1;

  logic        if_ack4, ls_ack4, mem_en4, busy4;
  logic [31:0] if_rdata4, ls_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic [3:0]  mem_we4;

  int n_checks = 0;
  int n_errors = 0;
  int ack4_cnt = 0;

  mem_port_arbiter #(.AW(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack1), .if_rdata_o(if_rdata1),
    .ls_rena_i(ls_rena), .ls_wena_i(ls_wena), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_wstrb_i(ls_wstrb), .ls_ack_o(ls_ack1), .ls_rdata_o(ls_rdata1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1), .busy_o(busy1)
  );

  mem_port_arbiter #(.AW(32), .RD_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n),
    .if_req_i(if_req4), .if_addr_i(if_addr), .if_ack_o(if_ack4), .if_rdata_o(if_rdata4),
    .ls_rena_i(ls_off), .ls_wena_i(ls_off), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_wstrb_i(ls_wstrb), .ls_ack_o(ls_ack4), .ls_rdata_o(ls_rdata4),
    .mem_en_o(mem_en4), .mem_we_o(mem_we4), .mem_addr_o(mem_addr4),
    .mem_wdata_o(mem_wdata4), .mem_rdata_i(mem_rdata4), .busy_o(busy4)
  );

  // Word memory with one-cycle registered read and byte-lane writes.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en1) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we1[b]) mem[mem_addr1[9:2]][8*b +: 8] <= mem_wdata1[8*b +: 8];
      end
      mem_rdata1 <= mem[mem_addr1[9:2]];
    end
  end

  // Four-stage read pipe returning an address-derived pattern.
  logic [31:0] pipe4 [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};
  always @(posedge clk) begin
    pipe4[0] <= mem_en4 ? (mem_addr4 ^ 32'hA5A5_0000) : 32'h0;
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end
  assign mem_rdata4 = pipe4[3];

  always @(posedge clk) begin
    if (if_ack4) ack4_cnt <= ack4_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph;
    int seen;
    mem[8'h40] = 32'hDEAD_BEEF;
    mem[8'h10] = 32'hAABB_CCDD;
    mem[8'h20] = 32'h1111_2222;
    ls_off  = 1'b0;
    rst_n   = 1'b0; rst4_n = 1'b0;
    if_req  = 1'b1; if_addr = 32'h100;
    ls_rena = 1'b1; ls_wena = 1'b1; ls_addr = 32'h80;
    ls_wdata = 32'h0; ls_wstrb = 4'hF; if_req4 = 1'b0;
    repeat (2) @(posedge clk);
    to_neg();
    check_eq("rst_busy",     32'(busy1), 32'd0);
    check_eq("rst_if_ack",   32'(if_ack1), 32'd0);
    check_eq("rst_ls_ack",   32'(ls_ack1), 32'd0);
    check_eq("rst_if_rdata", if_rdata1, 32'h0);
    check_eq("rst_ls_rdata", ls_rdata1, 32'h0);
    check_eq("rst_mem_en",   32'(mem_en1), 32'd0);
    check_eq("rst_mem_we",   32'(mem_we1), 32'd0);
    check_eq("rst_busy4",    32'(busy4), 32'd0);
    ls_wena = 1'b0; ls_wstrb = 4'h0;

    // Both requesters held from reset: LS wins first, then strict alternation.
    next_cycle();
    rst_n = 1'b1; rst4_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) next_cycle();
      to_neg();
      ph = n % 6;
      check_eq("tie_en", 32'(mem_en1), 32'(ph == 0 || ph == 3));
      if (mem_en1) check_eq("tie_addr", mem_addr1, (ph == 0) ? 32'h80 : 32'h100);
      check_eq("tie_ls_ack", 32'(ls_ack1), 32'(ph == 2));
      check_eq("tie_if_ack", 32'(if_ack1), 32'(ph == 5));
      if (ph == 2) check_eq("tie_ls_rdata", ls_rdata1, 32'h1111_2222);
      if (ph == 5) check_eq("tie_if_rdata", if_rdata1, 32'hDEAD_BEEF);
    end
    next_cycle();
    if_req = 1'b0; ls_rena = 1'b0;
    to_neg();
    check_eq("idle_en", 32'(mem_en1), 32'd0);
    check_eq("idle_busy", 32'(busy1), 32'd0);

    // Halfword store then load back the merged word.
    next_cycle();
    ls_wena = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h1234_5678; ls_wstrb = 4'b0011;
    to_neg();
    check_eq("st_en", 32'(mem_en1), 32'd1);
    check_eq("st_we", 32'(mem_we1), 32'h3);
    check_eq("st_addr", mem_addr1, 32'h40);
    check_eq("st_wdata", mem_wdata1, 32'h1234_5678);
    check_eq("st_ack_early", 32'(ls_ack1), 32'd0);
    next_cycle();
    to_neg();
    check_eq("st_ack", 32'(ls_ack1), 32'd1);
    check_eq("st_no_issue", 32'(mem_en1), 32'd0);
    next_cycle();
    ls_wena = 1'b0; ls_rena = 1'b1; ls_wstrb = 4'b0000;
    to_neg();
    check_eq("ld_en", 32'(mem_en1), 32'd1);
    check_eq("ld_we", 32'(mem_we1), 32'h0);
    next_cycle();
    to_neg();
    check_eq("ld_ack_rd", 32'(ls_ack1), 32'd0);
    next_cycle();
    ls_rena = 1'b0;
    to_neg();
    check_eq("ld_ack", 32'(ls_ack1), 32'd1);
    check_eq("ld_rdata", ls_rdata1, 32'hAABB_5678);
    check_eq("if_rdata_hold", if_rdata1, 32'hDEAD_BEEF);

    // rena and wena together behave as a store; ls_rdata untouched.
    next_cycle();
    ls_rena = 1'b1; ls_wena = 1'b1; ls_addr = 32'h80; ls_wdata = 32'hCAFE_F00D; ls_wstrb = 4'hF;
    to_neg();
    check_eq("rw_en", 32'(mem_en1), 32'd1);
    check_eq("rw_we", 32'(mem_we1), 32'hF);
    next_cycle();
    ls_rena = 1'b0; ls_wena = 1'b0; ls_wstrb = 4'h0;
    to_neg();
    check_eq("rw_ack", 32'(ls_ack1), 32'd1);
    check_eq("rw_rdata_hold", ls_rdata1, 32'hAABB_5678);

    // Load of the stored word, with a one-cycle fetch pulse during RD.
    next_cycle();
    ls_rena = 1'b1;
    to_neg();
    check_eq("pl_en", 32'(mem_en1), 32'd1);
    check_eq("pl_addr", mem_addr1, 32'h80);
    next_cycle();
    if_req = 1'b1; if_addr = 32'h100;
    to_neg();
    check_eq("pl_rd_en", 32'(mem_en1), 32'd0);
    next_cycle();
    if_req = 1'b0; ls_rena = 1'b0;
    to_neg();
    check_eq("pl_ls_ack", 32'(ls_ack1), 32'd1);
    check_eq("pl_ls_rdata", ls_rdata1, 32'hCAFE_F00D);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      to_neg();
      check_eq("pulse_en", 32'(mem_en1), 32'd0);
      check_eq("pulse_if_ack", 32'(if_ack1), 32'd0);
    end

    // RD_LAT=4 fetch aborted by reset two cycles after issue.
    next_cycle();
    if_req4 = 1'b1; if_addr = 32'h100;
    to_neg();
    check_eq("r4_en", 32'(mem_en4), 32'd1);
    next_cycle();
    to_neg();
    check_eq("r4_busy", 32'(busy4), 32'd1);
    next_cycle();
    rst4_n = 1'b0;
    #1;
    check_eq("r4_rst_busy", 32'(busy4), 32'd0);
    check_eq("r4_rst_en", 32'(mem_en4), 32'd0);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      to_neg();
      check_eq("r4_held_en", 32'(mem_en4), 32'd0);
      check_eq("r4_held_ack", 32'(if_ack4), 32'd0);
    end
    next_cycle();
    rst4_n = 1'b1;
    to_neg();
    check_eq("r4_no_ack", 32'(ack4_cnt), 32'd0);
    check_eq("r4_reissue", 32'(mem_en4), 32'd1);
    seen = 0;
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      to_neg();
      if (if_ack4 && seen == 0) seen = i;
    end
    if_req4 = 1'b0;
    check_eq("r4_ack_lat", 32'(seen), 32'd5);
    check_eq("r4_rdata", if_rdata4, 32'hA5A5_0100);
    check_eq("r4_ack_cnt", 32'(ack4_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing the single-port data/instruction memory between the instruction-fetch unit and the load/store path driven by the `ctrl` decode signals (`mem_rena`, `mem_wena`). It issues one memory access at a time, waits out the memory read latency, captures read data and returns a one-cycle acknowledge to the winning requester. It sits between the core's fetch and LSU stages and the memory macro.

## Interface
- `AW`, 32, address width
- `RD_LAT`, 1, cycles from issue (`mem_en`) to valid `mem_rdata`; legal 1..4

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch read request, held until `if_ack`
- `if_addr`  in  AW  fetch address, stable while `if_req`
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `if_rdata`  out  32  fetched word, valid when `if_ack`
- `ls_rena`  in  1  load request (from `mem_rena`)
- `ls_wena`  in  1  store request (from `mem_wena`)
- `ls_addr`  in  AW  load/store address
- `ls_wdata`  in  32  store data
- `ls_wstrb`  in  4  store byte enables
- `ls_ack`  out  1  one-cycle completion pulse for load/store
- `ls_rdata`  out  32  load word, valid when `ls_ack`
- `mem_en`  out  1  memory access strobe, one cycle per access
- `mem_we`  out  4  byte write enables
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  32  memory write data
- `mem_rdata`  in  32  memory read data
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, RD, DONE. Reset state IDLE.
- IDLE: LSU pending = `ls_rena|ls_wena`. If exactly one requester is pending, it wins; if both are pending, the one not served last wins (`last_if` flag, reset value 1 so LSU wins first tie).
- Issue happens in the IDLE cycle itself: `mem_en`=1, `mem_addr`/`mem_wdata`/`mem_we` driven combinationally from the winner; winner ID registered.
- Store (`ls_wena`=1): `mem_we`=`ls_wstrb` → DONE. Load or fetch: `mem_we`=0 → RD, latency counter loaded with RD_LAT.
- `ls_rena` and `ls_wena` both high: treated as a store.
- Store with `ls_wstrb`=0: access still issued, acked normally, memory content unchanged.
- RD: counter decrements each cycle; in the cycle it reads 1, `mem_rdata` is captured into the winner's rdata register → DONE.
- DONE: winner's ack=1 for exactly this cycle; no new issue; → IDLE. `last_if` is updated here.
- A request withdrawn before it is granted is dropped silently. A requester must not withdraw after grant.
- The rdata registers hold their value until the next capture for the same requester.

## Timing
- Reset (async, immediate): state IDLE, `if_ack`=`ls_ack`=0, `if_rdata`=`ls_rdata`=0, `busy`=0, `last_if`=1. `mem_en` and `mem_we` are gated with `rst_n`, so both are 0 while reset is asserted.
- Read: issue at cycle t, capture at end of t+RD_LAT, ack at t+RD_LAT+1, next issue no earlier than t+RD_LAT+2.
- Write: issue t, ack t+1, next issue t+2.
- Requests are ignored in RD and DONE. A request still high during the ack cycle is treated as new only if it is still present in the following IDLE cycle. Requesters drop the request in the ack cycle or present the next access.
- Reset during RD/DONE: the in-flight access is abandoned and no ack is produced. The requester must reissue.

## Structure
- Shared package / `define.v`: state encodings (`ARB_IDLE`, `ARB_RD`, `ARB_DONE`), requester IDs (`ARB_IF`, `ARB_LS`), RD_LAT bounds.
- Sub-module `rr_arb2`: combinational two-way round-robin pick from (`req_if`, `req_ls`, `last_if`). Everything else stays in the top.

## Test plan
- RD_LAT=1, `if_req`, `if_addr`=0x100, memory word 0xDEADBEEF → `mem_en` at t, `if_ack` at t+2 with `if_rdata`=0xDEADBEEF.
- `ls_wena`, `ls_addr`=0x40, `ls_wdata`=0x12345678, `ls_wstrb`=0b0011 → `mem_we`=0011 at t, `ls_ack` at t+1, then a load of 0x40 returns the low halfword 0x5678 merged with the old upper bytes.
- `if_req` and `ls_rena` both high from reset, held → grant order LS, IF, LS, IF; acks alternate, no starvation.
- RD_LAT=4, fetch issued, `rst_n` pulled low at t+2 → `busy`=0 immediately, no `if_ack` ever, next issue only after reset release.
- `ls_rena`=`ls_wena`=1 → write performed, `ls_ack` at t+1, `ls_rdata` unchanged. `if_req` pulsed one cycle during RD → never serviced.
